// File: rtl/nx_link_pkg.sv
// -----------------------------------------------------------------------------
// nx_link_pkg
// Shared types and constants for the host byte-stream link (nx_host_link and
// its serializer). Supplies a default message width when the common header
// has not already defined NX_MESSAGE_WIDTH.
// -----------------------------------------------------------------------------
`ifndef NX_MESSAGE_WIDTH
`define NX_MESSAGE_WIDTH 32
`endif

package nx_link_pkg;

    localparam int unsigned NX_LINK_BYTES = `NX_MESSAGE_WIDTH / 8;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_ACCUM,
        RX_PRESENT
    } nx_link_rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } nx_link_tx_state_t;

    // Controller message payloads (opaque words at this level)
    typedef logic [`NX_MESSAGE_WIDTH-1:0] nx_ctrl_msg_t;
    typedef logic [`NX_MESSAGE_WIDTH-1:0] nx_ctrl_msg_resp_t;

endpackage

// File: rtl/nx_msg_serializer.sv
// -----------------------------------------------------------------------------
// nx_msg_serializer
// Accepts one MSG_WIDTH-bit word and emits it as bytes, MSB first, over a
// valid/ready byte interface. A new word is accepted only from TX_IDLE, so
// word_ready_o rises the cycle after the last byte is taken.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   word_i/_valid_i     word input;  word_ready_o high in TX_IDLE
//   byte_o/_valid_o     byte output; byte_ready_i from the consumer
// -----------------------------------------------------------------------------
module nx_msg_serializer
    import nx_link_pkg::*;
#(
    parameter int unsigned MSG_WIDTH = `NX_MESSAGE_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [MSG_WIDTH-1:0] word_i,
    input  logic                 word_valid_i,
    output logic                 word_ready_o,
    output logic [7:0]           byte_o,
    output logic                 byte_valid_o,
    input  logic                 byte_ready_i
);

    localparam int unsigned BYTES = MSG_WIDTH / 8;
    localparam int unsigned IDX_W = $clog2(BYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES - 1);

    nx_link_tx_state_t    r_state;
    logic [MSG_WIDTH-1:0] r_sr;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_word_ready;
    logic                 r_byte_valid;
    logic [7:0]           r_byte;

    logic [MSG_WIDTH-1:0] w_sr_shift;

    assign w_sr_shift = r_sr << 8;

    // TX FSM: capture word, then walk bytes out top-first
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= TX_IDLE;
            r_sr         <= '0;
            r_idx        <= '0;
            r_word_ready <= 1'b1;
            r_byte_valid <= 1'b0;
            r_byte       <= '0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (word_valid_i && r_word_ready) begin
                        r_sr         <= word_i;
                        r_idx        <= '0;
                        r_byte       <= word_i[MSG_WIDTH-1 -: 8];
                        r_byte_valid <= 1'b1;
                        r_word_ready <= 1'b0;
                        r_state      <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (byte_ready_i) begin
                        if (r_idx == IDX_LAST) begin
                            r_byte_valid <= 1'b0;
                            r_word_ready <= 1'b1;
                            r_state      <= TX_IDLE;
                        end else begin
                            r_sr   <= w_sr_shift;
                            r_idx  <= r_idx + IDX_W'(1);
                            r_byte <= w_sr_shift[MSG_WIDTH-1 -: 8];
                        end
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign word_ready_o = r_word_ready;
    assign byte_o       = r_byte;
    assign byte_valid_o = r_byte_valid;

endmodule

// File: rtl/nx_host_link.sv
// -----------------------------------------------------------------------------
// nx_host_link
// Byte-stream adapter between the host transport and the controller ports.
//   Inbound : host bytes packed MSB-first into MSG_WIDTH-bit messages; a partial
//             message idle for TIMEOUT cycles is dropped (err_timeout_o pulse).
//   Outbound: controller response words serialised to host bytes, MSB first.
// Ports:
//   clk_i, rst_i                          clock, synchronous active-high reset
//   host_rx_data_i/_valid_i/_ready_o      inbound host bytes
//   host_tx_data_o/_valid_o/_ready_i      outbound host bytes
//   ctrl_data_o/_valid_o/ctrl_ready_i     assembled message to controller
//   resp_data_i/_valid_i/resp_ready_o     response word from controller
//   err_timeout_o                         one-cycle drop pulse
//   rx_busy_o                             partial message held
// -----------------------------------------------------------------------------
module nx_host_link
    import nx_link_pkg::*;
#(
    parameter int unsigned MSG_WIDTH = `NX_MESSAGE_WIDTH,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [7:0]           host_rx_data_i,
    input  logic                 host_rx_valid_i,
    output logic                 host_rx_ready_o,
    output logic [7:0]           host_tx_data_o,
    output logic                 host_tx_valid_o,
    input  logic                 host_tx_ready_i,
    output logic [MSG_WIDTH-1:0] ctrl_data_o,
    output logic                 ctrl_valid_o,
    input  logic                 ctrl_ready_i,
    input  logic [MSG_WIDTH-1:0] resp_data_i,
    input  logic                 resp_valid_i,
    output logic                 resp_ready_o,
    output logic                 err_timeout_o,
    output logic                 rx_busy_o
);

    localparam int unsigned BYTES   = MSG_WIDTH / 8;
    localparam int unsigned CNT_W   = $clog2(BYTES + 1);
    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam int unsigned TO_W    = TO_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TO_LAST = TO_EN ? TIMEOUT - 1 : 0;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BYTES);
    localparam logic [TO_W-1:0]  IDLE_MAX = TO_W'(TO_LAST);

    nx_link_rx_state_t    r_state;
    logic [MSG_WIDTH-1:0] r_sr;
    logic [CNT_W-1:0]     r_cnt;
    logic [TO_W-1:0]      r_idle_cnt;
    logic                 r_rx_ready;
    logic                 r_ctrl_valid;
    logic [MSG_WIDTH-1:0] r_ctrl_data;
    logic                 r_err;
    logic                 r_busy;

    logic                 w_rx_fire;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic [MSG_WIDTH-1:0] w_sr_next;

    assign w_rx_fire = host_rx_valid_i && r_rx_ready;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    // Top byte falls off; new byte enters at the bottom
    assign w_sr_next = MSG_WIDTH'({r_sr, host_rx_data_i});

    // RX FSM: accumulate bytes, present message, drop on inter-byte timeout.
    // The idle counter compares against TIMEOUT-1 so the drop lands exactly
    // when the count would reach TIMEOUT; a byte in that same cycle wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= RX_IDLE;
            r_sr         <= '0;
            r_cnt        <= '0;
            r_idle_cnt   <= '0;
            r_rx_ready   <= 1'b1;
            r_ctrl_valid <= 1'b0;
            r_ctrl_data  <= '0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                RX_IDLE, RX_ACCUM: begin
                    if (w_rx_fire) begin
                        r_sr       <= w_sr_next;
                        r_cnt      <= w_cnt_inc;
                        r_idle_cnt <= '0;
                        if (w_cnt_inc == CNT_FULL) begin
                            r_state      <= RX_PRESENT;
                            r_ctrl_valid <= 1'b1;
                            r_ctrl_data  <= w_sr_next;
                            r_rx_ready   <= 1'b0;
                            r_busy       <= 1'b0;
                        end else begin
                            r_state <= RX_ACCUM;
                            r_busy  <= 1'b1;
                        end
                    end else if (TO_EN && (r_state == RX_ACCUM)) begin
                        if (r_idle_cnt == IDLE_MAX) begin
                            r_state    <= RX_IDLE;
                            r_sr       <= '0;
                            r_cnt      <= '0;
                            r_idle_cnt <= '0;
                            r_busy     <= 1'b0;
                            r_err      <= 1'b1;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + TO_W'(1);
                        end
                    end
                end
                RX_PRESENT: begin
                    if (ctrl_ready_i) begin
                        r_state      <= RX_IDLE;
                        r_cnt        <= '0;
                        r_ctrl_valid <= 1'b0;
                        r_rx_ready   <= 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign host_rx_ready_o = r_rx_ready;
    assign ctrl_valid_o    = r_ctrl_valid;
    assign ctrl_data_o     = r_ctrl_data;
    assign err_timeout_o   = r_err;
    assign rx_busy_o       = r_busy;

    // Outbound path: response word to host bytes
    nx_msg_serializer #(
        .MSG_WIDTH (MSG_WIDTH)
    ) u_ser (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .word_i       (resp_data_i),
        .word_valid_i (resp_valid_i),
        .word_ready_o (resp_ready_o),
        .byte_o       (host_tx_data_o),
        .byte_valid_o (host_tx_valid_o),
        .byte_ready_i (host_tx_ready_i)
    );

endmodule

// File: tb/tb_nx_host_link.sv
// -----------------------------------------------------------------------------
// tb_nx_host_link
// Directed, table-driven bench for nx_host_link (MSG_WIDTH=32, TIMEOUT=16),
// plus hand-written sequences for the timeout corners.
// -----------------------------------------------------------------------------
module tb_nx_host_link;

    localparam int unsigned MW = 32;
    localparam int unsigned TO = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [7:0]    host_rx_data_i;
    logic          host_rx_valid_i;
    logic          host_rx_ready_o;
    logic [7:0]    host_tx_data_o;
    logic          host_tx_valid_o;
    logic          host_tx_ready_i;
    logic [MW-1:0] ctrl_data_o;
    logic          ctrl_valid_o;
    logic          ctrl_ready_i;
    logic [MW-1:0] resp_data_i;
    logic          resp_valid_i;
    logic          resp_ready_o;
    logic          err_timeout_o;
    logic          rx_busy_o;

    int errs   = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    nx_host_link #(
        .MSG_WIDTH (MW),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .host_rx_data_i  (host_rx_data_i),
        .host_rx_valid_i (host_rx_valid_i),
        .host_rx_ready_o (host_rx_ready_o),
        .host_tx_data_o  (host_tx_data_o),
        .host_tx_valid_o (host_tx_valid_o),
        .host_tx_ready_i (host_tx_ready_i),
        .ctrl_data_o     (ctrl_data_o),
        .ctrl_valid_o    (ctrl_valid_o),
        .ctrl_ready_i    (ctrl_ready_i),
        .resp_data_i     (resp_data_i),
        .resp_valid_i    (resp_valid_i),
        .resp_ready_o    (resp_ready_o),
        .err_timeout_o   (err_timeout_o),
        .rx_busy_o       (rx_busy_o)
    );

    // exp = {rx_ready, ctrl_valid, ctrl_data, tx_valid, tx_data, resp_ready, err, busy}
    typedef struct {
        string       name;
        logic        rst;
        logic        rxv;
        logic [7:0]  rxd;
        logic        crdy;
        logic        respv;
        logic [31:0] respd;
        logic        txrdy;
        logic [45:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic rst, logic rxv, logic [7:0] rxd,
                                logic crdy, logic respv, logic [31:0] respd, logic txrdy,
                                logic e_rxrdy, logic e_cv, logic [31:0] e_cd, logic e_txv,
                                logic [7:0] e_txd, logic e_resprdy, logic e_busy);
        vec_t v;
        v.name  = n;
        v.rst   = rst;
        v.rxv   = rxv;
        v.rxd   = rxd;
        v.crdy  = crdy;
        v.respv = respv;
        v.respd = respd;
        v.txrdy = txrdy;
        v.exp   = {e_rxrdy, e_cv, e_cd, e_txv, e_txd, e_resprdy, 1'b0, e_busy};
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        logic [45:0] act;

        rst_i           = 1'b1;
        host_rx_data_i  = '0;
        host_rx_valid_i = 1'b0;
        host_tx_ready_i = 1'b0;
        ctrl_ready_i    = 1'b0;
        resp_data_i     = '0;
        resp_valid_i    = 1'b0;

        //            name        rst rxv rxd    crdy rv rd            trdy | rxr cv cd            tv td     rr bsy
        vecs.push_back(mk("rst0",    1, 0, 8'h00, 0, 0, 32'h0,        0,    1, 0, 32'h0,        0, 8'h00, 1, 0));
        vecs.push_back(mk("rst1",    1, 0, 8'h00, 0, 0, 32'h0,        0,    1, 0, 32'h0,        0, 8'h00, 1, 0));
        // back-to-back message, controller always ready
        vecs.push_back(mk("t1_de",   0, 1, 8'hDE, 1, 0, 32'h0,        0,    1, 0, 32'h0,        0, 8'h00, 1, 1));
        vecs.push_back(mk("t1_ad",   0, 1, 8'hAD, 1, 0, 32'h0,        0,    1, 0, 32'h0,        0, 8'h00, 1, 1));
        vecs.push_back(mk("t1_be",   0, 1, 8'hBE, 1, 0, 32'h0,        0,    1, 0, 32'h0,        0, 8'h00, 1, 1));
        vecs.push_back(mk("t1_ef",   0, 1, 8'hEF, 1, 0, 32'h0,        0,    0, 1, 32'hDEADBEEF, 0, 8'h00, 1, 0));
        vecs.push_back(mk("t1_hs",   0, 0, 8'h00, 1, 0, 32'h0,        0,    1, 0, 32'hDEADBEEF, 0, 8'h00, 1, 0));
        // controller backpressure for 5 cycles, host keeps offering
        vecs.push_back(mk("t2_de",   0, 1, 8'hDE, 0, 0, 32'h0,        0,    1, 0, 32'hDEADBEEF, 0, 8'h00, 1, 1));
        vecs.push_back(mk("t2_ad",   0, 1, 8'hAD, 0, 0, 32'h0,        0,    1, 0, 32'hDEADBEEF, 0, 8'h00, 1, 1));
        vecs.push_back(mk("t2_be",   0, 1, 8'hBE, 0, 0, 32'h0,        0,    1, 0, 32'hDEADBEEF, 0, 8'h00, 1, 1));
        vecs.push_back(mk("t2_ef",   0, 1, 8'hEF, 0, 0, 32'h0,        0,    0, 1, 32'hDEADBEEF, 0, 8'h00, 1, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk($sformatf("t2_stall%0d", i),
                                     0, 1, 8'h11, 0, 0, 32'h0,        0,    0, 1, 32'hDEADBEEF, 0, 8'h00, 1, 0));
        vecs.push_back(mk("t2_hs",   0, 1, 8'h11, 1, 0, 32'h0,        0,    1, 0, 32'hDEADBEEF, 0, 8'h00, 1, 0));
        vecs.push_back(mk("t2_b11",  0, 1, 8'h11, 1, 0, 32'h0,        0,    1, 0, 32'hDEADBEEF, 0, 8'h00, 1, 1));
        vecs.push_back(mk("t2_b22",  0, 1, 8'h22, 1, 0, 32'h0,        0,    1, 0, 32'hDEADBEEF, 0, 8'h00, 1, 1));
        vecs.push_back(mk("t2_b33",  0, 1, 8'h33, 1, 0, 32'h0,        0,    1, 0, 32'hDEADBEEF, 0, 8'h00, 1, 1));
        vecs.push_back(mk("t2_b44",  0, 1, 8'h44, 1, 0, 32'h0,        0,    0, 1, 32'h11223344, 0, 8'h00, 1, 0));
        vecs.push_back(mk("t2_hs2",  0, 0, 8'h00, 1, 0, 32'h0,        0,    1, 0, 32'h11223344, 0, 8'h00, 1, 0));
        // response serialisation with toggling host ready
        vecs.push_back(mk("t5_cap",  0, 0, 8'h00, 1, 1, 32'h00012345, 0,    1, 0, 32'h11223344, 1, 8'h00, 0, 0));
        vecs.push_back(mk("t5_b0",   0, 0, 8'h00, 1, 1, 32'hFFFFFFFF, 1,    1, 0, 32'h11223344, 1, 8'h01, 0, 0));
        vecs.push_back(mk("t5_s1",   0, 0, 8'h00, 1, 1, 32'hFFFFFFFF, 0,    1, 0, 32'h11223344, 1, 8'h01, 0, 0));
        vecs.push_back(mk("t5_b1",   0, 0, 8'h00, 1, 1, 32'hFFFFFFFF, 1,    1, 0, 32'h11223344, 1, 8'h23, 0, 0));
        vecs.push_back(mk("t5_s2",   0, 0, 8'h00, 1, 1, 32'hFFFFFFFF, 0,    1, 0, 32'h11223344, 1, 8'h23, 0, 0));
        vecs.push_back(mk("t5_b2",   0, 0, 8'h00, 1, 1, 32'hFFFFFFFF, 1,    1, 0, 32'h11223344, 1, 8'h45, 0, 0));
        vecs.push_back(mk("t5_s3",   0, 0, 8'h00, 1, 1, 32'hFFFFFFFF, 0,    1, 0, 32'h11223344, 1, 8'h45, 0, 0));
        vecs.push_back(mk("t5_b3",   0, 0, 8'h00, 1, 0, 32'h0,        1,    1, 0, 32'h11223344, 0, 8'h45, 1, 0));
        vecs.push_back(mk("t5_idle", 0, 0, 8'h00, 1, 0, 32'h0,        0,    1, 0, 32'h11223344, 0, 8'h45, 1, 0));
        // reset mid-RX and mid-TX, then a fresh message
        vecs.push_back(mk("t6_a",    0, 1, 8'hA1, 1, 1, 32'hCAFEF00D, 0,    1, 0, 32'h11223344, 1, 8'hCA, 0, 1));
        vecs.push_back(mk("t6_b",    0, 1, 8'hA2, 1, 0, 32'h0,        1,    1, 0, 32'h11223344, 1, 8'hFE, 0, 1));
        vecs.push_back(mk("t6_rst",  1, 0, 8'h00, 0, 0, 32'h0,        0,    1, 0, 32'h0,        0, 8'h00, 1, 0));
        vecs.push_back(mk("t6_post", 0, 0, 8'h00, 1, 0, 32'h0,        0,    1, 0, 32'h0,        0, 8'h00, 1, 0));
        vecs.push_back(mk("t6_55",   0, 1, 8'h55, 1, 0, 32'h0,        0,    1, 0, 32'h0,        0, 8'h00, 1, 1));
        vecs.push_back(mk("t6_66",   0, 1, 8'h66, 1, 0, 32'h0,        0,    1, 0, 32'h0,        0, 8'h00, 1, 1));
        vecs.push_back(mk("t6_77",   0, 1, 8'h77, 1, 0, 32'h0,        0,    1, 0, 32'h0,        0, 8'h00, 1, 1));
        vecs.push_back(mk("t6_88",   0, 1, 8'h88, 1, 0, 32'h0,        0,    0, 1, 32'h55667788, 0, 8'h00, 1, 0));
        vecs.push_back(mk("t6_hs",   0, 0, 8'h00, 1, 0, 32'h0,        0,    1, 0, 32'h55667788, 0, 8'h00, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_i           = vecs[i].rst;
            host_rx_valid_i = vecs[i].rxv;
            host_rx_data_i  = vecs[i].rxd;
            ctrl_ready_i    = vecs[i].crdy;
            resp_valid_i    = vecs[i].respv;
            resp_data_i     = vecs[i].respd;
            host_tx_ready_i = vecs[i].txrdy;
            step();
            act = {host_rx_ready_o, ctrl_valid_o, ctrl_data_o, host_tx_valid_o,
                   host_tx_data_o, resp_ready_o, err_timeout_o, rx_busy_o};
            check(vecs[i].name, 64'(act), 64'(vecs[i].exp));
        end

        // Timeout: partial 12 34 dropped 16 cycles after the last handshake
        rst_i = 1'b0; ctrl_ready_i = 1'b1; resp_valid_i = 1'b0; host_tx_ready_i = 1'b0;
        host_rx_valid_i = 1'b1; host_rx_data_i = 8'h12; step();
        host_rx_data_i = 8'h34; step();
        host_rx_valid_i = 1'b0;
        check("t3_busy0", 64'(rx_busy_o), 64'd1);
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("t3_err_%0d", k), 64'(err_timeout_o), 64'(k == 16));
            check($sformatf("t3_busy_%0d", k), 64'(rx_busy_o), 64'(k < 16));
        end
        host_rx_valid_i = 1'b1;
        host_rx_data_i = 8'h01; step();
        host_rx_data_i = 8'h02; step();
        host_rx_data_i = 8'h03; step();
        host_rx_data_i = 8'h04; step();
        host_rx_valid_i = 1'b0;
        check("t3_msg_valid", 64'(ctrl_valid_o), 64'd1);
        check("t3_msg_data", 64'(ctrl_data_o), 64'h01020304);
        step();
        check("t3_msg_hs", 64'(ctrl_valid_o), 64'd0);

        // Byte arriving in the expiry cycle wins over the drop
        host_rx_valid_i = 1'b1;
        host_rx_data_i = 8'hAA; step();
        host_rx_data_i = 8'hBB; step();
        host_rx_data_i = 8'hCC; step();
        host_rx_valid_i = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            check($sformatf("t4_err_%0d", k), 64'(err_timeout_o), 64'd0);
        end
        check("t4_busy_pre", 64'(rx_busy_o), 64'd1);
        host_rx_valid_i = 1'b1; host_rx_data_i = 8'hDD; step();
        host_rx_valid_i = 1'b0; ctrl_ready_i = 1'b0;
        check("t4_err_expiry", 64'(err_timeout_o), 64'd0);
        check("t4_valid", 64'(ctrl_valid_o), 64'd1);
        check("t4_data", 64'(ctrl_data_o), 64'hAABBCCDD);
        // Long controller stall never triggers a drop
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("t4_stall_%0d", k),
                  64'({err_timeout_o, ctrl_valid_o, host_rx_ready_o}), 64'b010);
        end
        ctrl_ready_i = 1'b1; step();
        check("t4_hs", 64'({err_timeout_o, ctrl_valid_o, host_rx_ready_o}), 64'b001);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/nx_host_link.md
Name: nx_host_link

Overview:
Byte-stream adapter between the host transport (UART/USB FIFO, 8-bit valid/ready) and the controller's word-wide message ports.
- Inbound: packs host bytes MSB-first into NX_MESSAGE_WIDTH-bit control messages for the controller inbound port.
- Outbound: serialises controller response words back into bytes, MSB first.
- Discards stalled partial messages after a programmable inter-byte timeout, so host and controller stay word-aligned.

Parameters:
MSG_WIDTH, `NX_MESSAGE_WIDTH (32), message width in bits; must be a multiple of 8 and at least 16.
TIMEOUT, 1024, cycles without an accepted byte before a partial inbound message is dropped; 0 disables the timeout.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset (synchronous, active-high)
host_rx_data_i  in  8  byte from host
host_rx_valid_i  in  1  host byte valid
host_rx_ready_o  out  1  block accepts host byte
host_tx_data_o  out  8  byte to host
host_tx_valid_o  out  1  outbound byte valid
host_tx_ready_i  in  1  host accepts byte
ctrl_data_o  out  MSG_WIDTH  assembled message (nx_ctrl_msg_t)
ctrl_valid_o  out  1  message valid
ctrl_ready_i  in  1  controller accepts message
resp_data_i  in  MSG_WIDTH  response word (nx_ctrl_msg_resp_t)
resp_valid_i  in  1  response valid
resp_ready_o  out  1  block accepts response
err_timeout_o  out  1  one-cycle pulse when a partial message is dropped
rx_busy_o  out  1  high while a partial message is held (RX state ACCUM)

Behaviour:
- One clock domain; reset is synchronous and active-high.
- BYTES = MSG_WIDTH/8.
- Handshake rules:
  - A transfer occurs on valid && ready.
  - Valid never depends on ready.
  - Data is held stable while valid is high and ready is low.
- Reset values: ctrl_valid_o=0, host_tx_valid_o=0, err_timeout_o=0, rx_busy_o=0, ctrl_data_o=0, host_tx_data_o=0, host_rx_ready_o=1, resp_ready_o=1.
- Reset mid-operation discards all partial and pending state in both directions, with no error pulse.
- RX FSM has three states: IDLE, ACCUM, PRESENT.
  - host_rx_ready_o = (state != PRESENT).
  - Each accepted byte shifts into the shift register: sr = {sr[MSG_WIDTH-9:0], byte}. The byte counter increments.
  - IDLE -> ACCUM on the first byte. Any byte that makes count == BYTES moves the FSM to PRESENT.
  - PRESENT: ctrl_valid_o=1 and ctrl_data_o=sr, starting the cycle after the last byte. There is no bypass.
  - On ctrl_ready_i, the FSM returns to IDLE and the counter clears. host_rx_ready_o rises the next cycle.
  - Peak throughput is one message per BYTES+1 cycles.
- Timeout (ACCUM only):
  - The idle counter clears on every accepted byte and increments otherwise.
  - When the counter reaches TIMEOUT: drop the partial message, clear the counters, go to IDLE, and pulse err_timeout_o for one cycle.
  - If a byte is accepted in the expiry cycle, the byte wins: no drop, counter cleared.
  - TIMEOUT=0: the counter is unused and there is never a drop.
  - No timeout runs in IDLE or PRESENT; controller backpressure never causes a drop.
- TX FSM has two states: IDLE, SEND.
  - resp_ready_o = (state == IDLE).
  - On a response handshake, capture the word into the TX shift register, clear the index, and enter SEND.
  - SEND: host_tx_valid_o=1 and host_tx_data_o = top byte of the shift register.
  - On host_tx_ready_i: shift left 8 and increment the index. After byte BYTES-1 is accepted, return to IDLE.
  - A new response cannot be accepted in the same cycle as the last byte; resp_ready_o rises the next cycle.
- RX and TX paths are fully independent; simultaneous activity on both is legal.
- Counter widths: byte counter is $clog2(BYTES+1) bits; timeout counter is $clog2(TIMEOUT+1) bits. Neither wraps.

Decomposition:
- Shared package nx_link_pkg holds:
  - nx_link_rx_state_t {IDLE, ACCUM, PRESENT}
  - nx_link_tx_state_t {IDLE, SEND}
  - localparam NX_LINK_BYTES = `NX_MESSAGE_WIDTH/8
- Message typedefs come from the existing common header.
- The TX path is a natural sub-module, nx_msg_serializer (word in, bytes out, parameter MSG_WIDTH). It is instantiated once.
- The RX path stays in the top level.

Test Plan:
1. Bytes DE AD BE EF back-to-back, ctrl_ready_i=1 -> ctrl_valid_o high for one cycle, the cycle after EF, with ctrl_data_o=0xDEADBEEF; host_rx_ready_o low in that cycle.
2. Same bytes, ctrl_ready_i low for 5 cycles -> ctrl_data_o stable and host_rx_ready_o=0 for all 5 cycles, no err_timeout_o; next bytes accepted one cycle after the handshake.
3. TIMEOUT=16: send 12 34, then idle -> err_timeout_o pulses once, 16 cycles after the 34 handshake, and rx_busy_o falls. Then 01 02 03 04 -> 0x01020304.
4. TIMEOUT=16: 3 bytes, then the 4th byte lands in the expiry cycle -> no error; message 0x....04 delivered intact.
5. Response 0x00012345 with host_tx_ready_i toggling 1,0,1,0 -> bytes 00 01 23 45 in order, each held while stalled; resp_ready_o=0 until one cycle after 45 is accepted.
6. rst_i asserted after 2 of 4 RX bytes and mid-TX -> all valids 0 and both readys 1 the cycle after reset; a fresh 4-byte message then decodes correctly.
